gat_bram_load_ctrl: RTL
=======================

# gat_bram_load_ctrl

Parametrised multi-channel host-to-core BRAM loader for the GAT accelerator. It sits between the AXI-BRAM-controller ports of the block design and `gat_top`. It converts byte addresses to word addresses, truncates 32-bit host words to channel width and registers every write toward the core BRAMs. It counts accepted writes per channel and, once all channels reach their programmed lengths, raises sticky load-done flags and a single core-start pulse. It also provides a pipelined, valid-tagged read-back path for the new-feature BRAM.

## Interface
- `TOP_WIDTH`, 32, host bus data width
- `NUM_CH`, 3, number of load channels (h_data, node_info, weight)
- `DATA_WIDTH`, 20, core BRAM data width; must be ≤ `TOP_WIDTH`
- `DEPTH`, 242101, per-channel word depth
- `ADDR_W`, `$clog2(DEPTH)`, word address width
- `CNT_W`, `ADDR_W+1`, write-counter width
- `NEW_FEATURE_WIDTH`, 32, feature word width; must be ≤ `TOP_WIDTH`
- `FEAT_DEPTH`, 43328, feature BRAM depth
- `FEAT_ADDR_W`, `$clog2(FEAT_DEPTH)`, feature word address width

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `gat_layer` in 1: layer select. Any change clears all load state.
- `load_clear` in 1: synchronous clear of counters, flags and FSM.
- `ch_expected` in `NUM_CH*CNT_W`: packed expected write count per channel. 0 means the channel is unused and counts as done.
- `host_din` in `NUM_CH*TOP_WIDTH`: packed host write data.
- `host_ena`, `host_wea` in `NUM_CH` each: per-channel enable and write-enable.
- `host_addra` in `NUM_CH*(ADDR_W+2)`: packed byte addresses.
- `bram_din` out `NUM_CH*DATA_WIDTH`: data to core BRAMs, equal to `host_din[DATA_WIDTH-1:0]`.
- `bram_we` out `NUM_CH`: core BRAM write strobe.
- `bram_addr` out `NUM_CH*ADDR_W`: core BRAM address, equal to `host_addra[ADDR_W+1:2]`.
- `load_done` out `NUM_CH`: sticky per-channel done flag.
- `all_done` out 1: AND of `load_done`.
- `core_start` out 1: one-cycle pulse when the FSM enters READY.
- `addr_err` out `NUM_CH`: sticky out-of-range write flag.
- `feat_rd_en` in 1: host read request.
- `feat_addrb` in `FEAT_ADDR_W+2`: host read byte address.
- `feat_core_addr` out `FEAT_ADDR_W`: address to the core feature BRAM (1-cycle read latency).
- `feat_core_dout` in `NEW_FEATURE_WIDTH`: data from the core feature BRAM.
- `feat_dout` out `TOP_WIDTH`: read data, zero-extended.
- `feat_dvalid` out 1: `feat_dout` is valid.

## Operation
- A write is accepted when `host_ena&host_wea` is high and the word address is < `DEPTH`.
  - An accepted write is registered onto the `bram_*` outputs.
  - An accepted write increments that channel's counter, which saturates at `2^CNT_W-1`.
- A write with word address ≥ `DEPTH` is dropped: no `bram_we`, no count, and `addr_err[c]` is set.
- `load_done[c]` is set when the counter equals `ch_expected[c]`, or immediately if `ch_expected[c]==0`. It stays set until a clear.
- Writes after done are still forwarded and counted. Done never deasserts on its own.
- FSM states:
  - IDLE → LOADING on the first accepted write.
  - LOADING → READY when `all_done` is high. `core_start` pulses on this transition.
  - READY holds until cleared.
  - IDLE → READY directly if every `ch_expected` is 0.
- Clear (`load_clear`, or a change of `gat_layer` detected against a registered copy) resets counters, `load_done`, `addr_err` and the FSM to IDLE.
- Clear in the same cycle as a write: the clear wins for counting (the write is not counted), but the write is still forwarded to the BRAM.
- Read path: a registered 3-stage pipeline. Requests may issue every cycle, and responses return in order.

## Timing
- Reset values: all outputs 0; FSM in IDLE; counters 0; the registered copy of `gat_layer` loads `gat_layer` on the first clock after reset.
- Write path: an accepted write at cycle N gives `bram_we/addr/din` at N+1.
- If that write completes a count, `load_done[c]` is high from N+1.
- `all_done` is high at N+1 when the completing channel is last. `core_start` is high for cycle N+2 only.
- Read path:
  - `feat_rd_en` at N gives `feat_core_addr` at N+1.
  - The BRAM returns data at N+2.
  - `feat_dout` and `feat_dvalid` are valid at N+3.
  - `feat_dvalid` is low in any cycle without a matching request.
- Reset mid-load: all outputs return to 0 asynchronously. In-flight reads are discarded.

## Test plan
- **Normal load:** `ch_expected={4,2,3}`; write 4/2/3 words at byte addresses 0,4,8,12 → `bram_addr` 0..3 one cycle later; `load_done` sets on the last write of each channel; exactly one `core_start` pulse 2 cycles after the last write.
- **Truncation:** `host_din=32'hABCDE123` with `DATA_WIDTH=20` → `bram_din=20'hDE123`.
- **Out of range:** a write at byte address `DEPTH*4` → no `bram_we`, `addr_err[c]=1`, count unchanged; a later valid write is still counted.
- **Clear collision:** `load_clear` in the same cycle as the final expected write → BRAM written, count 0, `load_done=0`, FSM in IDLE.
- **Layer change:** toggle `gat_layer` in READY → all flags cleared next cycle; a reload produces a new `core_start`.
- **Read pipeline:** back-to-back reads at byte addresses 0,4,8 with core data `0x11,0x22,0x33` → `feat_dout` `0x11,0x22,0x33` on cycles N+3..N+5, with `feat_dvalid` high for those 3 cycles.

Source files
------------

// File: rtl/gat_bram_load_ctrl.sv
// gat_bram_load_ctrl
// Loads the GAT core BRAMs from the host AXI-BRAM ports, one channel per BRAM.
// Host writes arrive as byte addresses and 32-bit words. They are converted to
// word addresses, truncated to the core data width and registered toward the core.
// Accepted writes are counted per channel. When every channel reaches its
// programmed length, sticky done flags rise and a single core_start pulse fires.
// A 3-stage, valid-tagged pipeline returns new-feature BRAM words to the host.

module gat_bram_load_ctrl #(
   parameter int TOP_WIDTH         = 32,
   parameter int NUM_CH            = 3,
   parameter int DATA_WIDTH        = 20,
   parameter int DEPTH             = 242101,
   parameter int ADDR_W            = $clog2(DEPTH),
   parameter int CNT_W             = ADDR_W + 1,
   parameter int NEW_FEATURE_WIDTH = 32,
   parameter int FEAT_DEPTH        = 43328,
   parameter int FEAT_ADDR_W       = $clog2(FEAT_DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            gat_layer,
   input  logic                            load_clear,
   input  logic [NUM_CH*CNT_W-1:0]         ch_expected,
   input  logic [NUM_CH*TOP_WIDTH-1:0]     host_din,
   input  logic [NUM_CH-1:0]               host_ena,
   input  logic [NUM_CH-1:0]               host_wea,
   input  logic [NUM_CH*(ADDR_W+2)-1:0]    host_addra,
   output logic [NUM_CH*DATA_WIDTH-1:0]    bram_din,
   output logic [NUM_CH-1:0]               bram_we,
   output logic [NUM_CH*ADDR_W-1:0]        bram_addr,
   output logic [NUM_CH-1:0]               load_done,
   output logic                            all_done,
   output logic                            core_start,
   output logic [NUM_CH-1:0]               addr_err,
   input  logic                            feat_rd_en,
   input  logic [FEAT_ADDR_W+1:0]          feat_addrb,
   output logic [FEAT_ADDR_W-1:0]          feat_core_addr,
   input  logic [NEW_FEATURE_WIDTH-1:0]    feat_core_dout,
   output logic [TOP_WIDTH-1:0]            feat_dout,
   output logic                            feat_dvalid
);

   // Host byte-address width per channel.
   localparam int BA_W = ADDR_W + 2;
   // DEPTH held one bit wider so a power-of-two depth does not wrap to zero.
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOADING,
      ST_READY
   } state_t;

   state_t            state;

   logic [ADDR_W-1:0] waddr    [NUM_CH];
   logic [CNT_W-1:0]  exp_cnt  [NUM_CH];
   logic [CNT_W-1:0]  cnt      [NUM_CH];
   logic [CNT_W-1:0]  cnt_nxt  [NUM_CH];
   logic [NUM_CH-1:0] wr_req;
   logic [NUM_CH-1:0] in_range;
   logic [NUM_CH-1:0] accept;

   logic              gat_layer_q;
   logic              layer_seen;
   logic              layer_clear;
   logic              clr;

   logic              rd_v1;
   logic              rd_v2;

   // Byte offsets and the truncated upper data bits are intentionally dropped.
   logic              unused_bits;
   assign unused_bits = ^{host_din, host_addra, feat_addrb};

   // A layer change only counts once the registered copy has been loaded.
   assign layer_clear = layer_seen & (gat_layer != gat_layer_q);
   assign clr         = load_clear | layer_clear;
   assign all_done    = &load_done;

   // Per-channel address decode, acceptance and next counter value.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      wr_req   = '0;
      in_range = '0;
      accept   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         waddr[c]    = host_addra[c*BA_W+2 +: ADDR_W];
         exp_cnt[c]  = ch_expected[c*CNT_W +: CNT_W];
         wr_req[c]   = host_ena[c] & host_wea[c];
         in_range[c] = ({1'b0, waddr[c]} < DEPTH_L);
         accept[c]   = wr_req[c] & in_range[c];
         cnt_nxt[c]  = (accept[c] && (cnt[c] != CNT_MAX)) ? cnt[c] + CNT_W'(1) : cnt[c];
      end
   end

   // Register accepted writes onto the core BRAM ports; a clear does not block them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         bram_we   <= '0;
         bram_addr <= '0;
         bram_din  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            bram_we[c] <= accept[c];
            if (accept[c]) begin
               bram_addr[c*ADDR_W +: ADDR_W]         <= waddr[c];
               bram_din[c*DATA_WIDTH +: DATA_WIDTH] <= host_din[c*TOP_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Registered copy of gat_layer used to detect a layer change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gat_layer_q <= 1'b0;
         layer_seen  <= 1'b0;
      end else begin
         gat_layer_q <= gat_layer;
         layer_seen  <= 1'b1;
      end
   end

   // Write counters, sticky done flags and sticky address-error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the counters are a handful of flops, not a RAM, so resetting every entry is intended.
         for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
         load_done <= '0;
         addr_err  <= '0;
      end else if (clr) begin
         for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
         load_done <= '0;
         addr_err  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt[c]       <= cnt_nxt[c];
            load_done[c] <= load_done[c] | (exp_cnt[c] == '0) | (cnt_nxt[c] == exp_cnt[c]);
            addr_err[c]  <= addr_err[c] | (wr_req[c] & ~in_range[c]);
         end
      end
   end

   // Load sequencing FSM; core_start is a registered one-cycle pulse on entry to READY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         core_start <= 1'b0;
      end else begin
         core_start <= 1'b0;
         if (clr) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (all_done) begin
                     state      <= ST_READY;
                     core_start <= 1'b1;
                  end else if (|accept) begin
                     state <= ST_LOADING;
                  end
               end
               ST_LOADING: begin
                  if (all_done) begin
                     state      <= ST_READY;
                     core_start <= 1'b1;
                  end
               end
               ST_READY: state <= ST_READY;
               default:  state <= ST_IDLE;
            endcase
         end
      end
   end

   // Feature read-back: address stage, BRAM latency stage, output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feat_core_addr <= '0;
         rd_v1          <= 1'b0;
         rd_v2          <= 1'b0;
         feat_dout      <= '0;
         feat_dvalid    <= 1'b0;
      end else begin
         if (feat_rd_en) feat_core_addr <= feat_addrb[FEAT_ADDR_W+1:2];
         rd_v1       <= feat_rd_en;
         rd_v2       <= rd_v1;
         if (rd_v2) feat_dout <= TOP_WIDTH'(feat_core_dout);
         feat_dvalid <= rd_v2;
      end
   end

endmodule
